lsu_mem_arbiter: RTL and testbench

Shares the single-port, word-wide data memory of the RISC-V core between two requesters: the core's load/store unit (LB/LH/LW/LBU/LHU/SB/SH/SW) and a word-only loader/debug port that preloads or inspects memory. It provides round-robin arbitration, a request/grant/response handshake, byte-lane steering with write strobes, sign/zero extension on loads, and alignment checking. It sits between the datapath's LSU and the data memory macro.

---
 rtl/lsu_mem_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_lsu_mem_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_arbiter.sv
// Round-robin arbiter sharing one word-wide data memory between the core LSU and a loader port.
// Handles byte-lane steering, write strobes, load extension and core alignment/range checks.
module lsu_mem_arbiter #(
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              c_req,
   input  logic              c_we,
   input  logic [2:0]        c_funct3,
   input  logic [31:0]       c_addr,
   input  logic [31:0]       c_wdata,
   output logic              c_gnt,
   output logic              c_rvalid,
   output logic [31:0]       c_rdata,
   output logic              c_err,
   input  logic              l_req,
   input  logic              l_we,
   input  logic [ADDR_W-1:0] l_addr,
   input  logic [31:0]       l_wdata,
   output logic              l_gnt,
   output logic              l_rvalid,
   output logic [31:0]       l_rdata,
   output logic              m_en,
   output logic [3:0]        m_we,
   output logic [ADDR_W-1:0] m_addr,
   output logic [31:0]       m_wdata,
   input  logic [31:0]       m_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_RESP} state_t;

   state_t              r_state;
   logic                r_last_core;
   logic                r_sel_core;
   logic                r_we;
   logic                r_err;
   logic [2:0]          r_funct3;
   logic [1:0]          r_boff;
   logic                r_m_en;
   logic [3:0]          r_m_we;
   logic [ADDR_W-1:0]   r_m_addr;
   logic [31:0]         r_m_wdata;
   logic                r_c_rvalid;
   logic                r_c_err;
   logic                r_l_rvalid;

   logic                w_idle;
   logic                w_pick_core;
   logic                w_pick_ldr;
   logic                w_legal;
   logic                w_misal;
   logic                w_oor;
   logic                w_cerr;
   logic [3:0]          w_c_we;
   logic [31:0]         w_c_wdata;
   logic [15:0]         w_sel;
   logic [31:0]         w_ext;

   // Grant is combinational in IDLE; gating with reset keeps it low while reset is held.
   assign w_idle      = (r_state == ST_IDLE) && reset;
   assign w_pick_core = c_req && (!l_req || !r_last_core);
   assign w_pick_ldr  = l_req && !w_pick_core;
   assign c_gnt       = w_idle && w_pick_core;
   assign l_gnt       = w_idle && w_pick_ldr;

   assign w_oor  = |c_addr[31:ADDR_W+2];
   assign w_cerr = !w_legal || w_misal || w_oor;

   always_comb begin
      w_legal = 1'b0;
      w_misal = 1'b0;
      case (c_funct3)
         3'b000:        w_legal = 1'b1;
         3'b001: begin  w_legal = 1'b1;   w_misal = c_addr[0];    end
         3'b010: begin  w_legal = 1'b1;   w_misal = |c_addr[1:0]; end
         3'b100:        w_legal = !c_we;
         3'b101: begin  w_legal = !c_we;  w_misal = c_addr[0];    end
         default:       w_legal = 1'b0;
      endcase
   end

   always_comb begin
      w_c_we    = 4'b1111;
      w_c_wdata = c_wdata;
      case (c_funct3[1:0])
         2'b00: begin
            w_c_we    = 4'b0001 << c_addr[1:0];
            w_c_wdata = {4{c_wdata[7:0]}};
         end
         2'b01: begin
            w_c_we    = c_addr[1] ? 4'b1100 : 4'b0011;
            w_c_wdata = {2{c_wdata[15:0]}};
         end
         default: begin
            w_c_we    = 4'b1111;
            w_c_wdata = c_wdata;
         end
      endcase
   end

   assign w_sel = 16'(m_rdata >> {r_boff, 3'b000});

   always_comb begin
      w_ext = '0;
      case (r_funct3)
         3'b000:  w_ext = {{24{w_sel[7]}}, w_sel[7:0]};
         3'b001:  w_ext = {{16{w_sel[15]}}, w_sel[15:0]};
         3'b010:  w_ext = m_rdata;
         3'b100:  w_ext = {24'b0, w_sel[7:0]};
         3'b101:  w_ext = {16'b0, w_sel[15:0]};
         default: w_ext = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_last_core <= 1'b0;
         r_sel_core  <= 1'b0;
         r_we        <= 1'b0;
         r_err       <= 1'b0;
         r_funct3    <= '0;
         r_boff      <= '0;
         r_m_en      <= 1'b0;
         r_m_we      <= '0;
         r_m_addr    <= '0;
         r_m_wdata   <= '0;
         r_c_rvalid  <= 1'b0;
         r_c_err     <= 1'b0;
         r_l_rvalid  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (c_req || l_req) begin
                  r_state     <= ST_ISSUE;
                  r_last_core <= w_pick_core;
                  r_sel_core  <= w_pick_core;
                  if (w_pick_core) begin
                     r_we      <= c_we;
                     r_funct3  <= c_funct3;
                     r_boff    <= c_addr[1:0];
                     r_err     <= w_cerr;
                     r_m_en    <= !w_cerr;
                     r_m_we    <= (c_we && !w_cerr) ? w_c_we : '0;
                     r_m_addr  <= c_addr[ADDR_W+1:2];
                     r_m_wdata <= c_we ? w_c_wdata : '0;
                  end else begin
                     r_we      <= l_we;
                     r_funct3  <= 3'b010;
                     r_boff    <= '0;
                     r_err     <= 1'b0;
                     r_m_en    <= 1'b1;
                     r_m_we    <= l_we ? 4'b1111 : 4'b0000;
                     r_m_addr  <= l_addr;
                     r_m_wdata <= l_wdata;
                  end
               end
            end
            ST_ISSUE: begin
               r_state    <= ST_RESP;
               r_m_en     <= 1'b0;
               r_m_we     <= '0;
               r_m_addr   <= '0;
               r_m_wdata  <= '0;
               r_c_rvalid <= r_sel_core;
               r_c_err    <= r_sel_core && r_err;
               r_l_rvalid <= !r_sel_core;
            end
            ST_RESP: begin
               r_state    <= ST_IDLE;
               r_c_rvalid <= 1'b0;
               r_c_err    <= 1'b0;
               r_l_rvalid <= 1'b0;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign m_en     = r_m_en;
   assign m_we     = r_m_we;
   assign m_addr   = r_m_addr;
   assign m_wdata  = r_m_wdata;
   assign c_rvalid = r_c_rvalid;
   assign c_err    = r_c_err;
   assign l_rvalid = r_l_rvalid;
   assign c_rdata  = (r_c_rvalid && !r_c_err && !r_we) ? w_ext : '0;
   assign l_rdata  = (r_l_rvalid && !r_we) ? m_rdata : '0;
   assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Directed bench for lsu_mem_arbiter: core access table, loader accesses, contention and reset mid-op.
module tb_lsu_mem_arbiter;
   localparam int unsigned AW = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          c_req, c_we;
   logic [2:0]    c_funct3;
   logic [31:0]   c_addr, c_wdata;
   logic          c_gnt, c_rvalid, c_err;
   logic [31:0]   c_rdata;
   logic          l_req, l_we;
   logic [AW-1:0] l_addr;
   logic [31:0]   l_wdata;
   logic          l_gnt, l_rvalid;
   logic [31:0]   l_rdata;
   logic          m_en;
   logic [3:0]    m_we;
   logic [AW-1:0] m_addr;
   logic [31:0]   m_wdata;
   logic [31:0]   m_rdata;
   logic          busy;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  mwe;
      logic [31:0] mwdata;
      logic [31:0] rdata;
      logic        err;
   } vec_t;

   vec_t tbl[$];

   always #5 clk = ~clk;

   lsu_mem_arbiter #(.ADDR_W(AW)) dut (
      .clk(clk), .reset(reset),
      .c_req(c_req), .c_we(c_we), .c_funct3(c_funct3), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_err(c_err),
      .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
      .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
      .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
      .busy(busy)
   );

   // Behavioural single-port memory with byte strobes and one-cycle read latency.
   logic [31:0] mem [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (m_en) begin
         if (m_we == 4'b0000) m_rdata <= mem[m_addr];
         else for (int b = 0; b < 4; b++) if (m_we[b]) mem[m_addr][8*b +: 8] <= m_wdata[8*b +: 8];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] mwe,
                               input logic [31:0] mwdata, input logic [31:0] rdata, input logic err);
      vec_t v;
      v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
      v.mwe = mwe; v.mwdata = mwdata; v.rdata = rdata; v.err = err;
      return v;
   endfunction

   task automatic core_op(input vec_t v);
      logic seen;
      c_req = 1'b1; c_we = v.we; c_funct3 = v.f3; c_addr = v.addr; c_wdata = v.wdata;
      seen = 1'b0;
      for (int n = 0; n < 10; n++) begin
         if (c_gnt) begin seen = 1'b1; break; end
         step();
      end
      chk("c_gnt", {31'b0, seen}, 32'd1);
      if (!seen) begin c_req = 1'b0; return; end
      step();
      c_req = 1'b0;
      chk("issue_m_en", {31'b0, m_en}, {31'b0, !v.err});
      if (!v.err) begin
         chk("issue_m_we", {28'b0, m_we}, {28'b0, v.mwe});
         chk("issue_m_addr", {24'b0, m_addr}, {24'b0, v.addr[AW+1:2]});
         if (v.we) chk("issue_m_wdata", m_wdata, v.mwdata);
      end
      step();
      chk("resp_c_rvalid", {31'b0, c_rvalid}, 32'd1);
      chk("resp_c_err", {31'b0, c_err}, {31'b0, v.err});
      chk("resp_c_rdata", c_rdata, v.rdata);
      chk("resp_l_rvalid", {31'b0, l_rvalid}, 32'd0);
      chk("resp_m_en", {31'b0, m_en}, 32'd0);
      step();
      chk("c_rvalid_pulse", {31'b0, c_rvalid}, 32'd0);
   endtask

   task automatic loader_op(input logic we, input logic [AW-1:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp_rdata);
      logic seen;
      l_req = 1'b1; l_we = we; l_addr = addr; l_wdata = wdata;
      seen = 1'b0;
      for (int n = 0; n < 10; n++) begin
         if (l_gnt) begin seen = 1'b1; break; end
         step();
      end
      chk("l_gnt", {31'b0, seen}, 32'd1);
      if (!seen) begin l_req = 1'b0; return; end
      step();
      l_req = 1'b0;
      chk("l_issue_m_en", {31'b0, m_en}, 32'd1);
      chk("l_issue_m_we", {28'b0, m_we}, we ? 32'hF : 32'h0);
      chk("l_issue_m_addr", {24'b0, m_addr}, {24'b0, addr});
      step();
      chk("l_resp_rvalid", {31'b0, l_rvalid}, 32'd1);
      chk("l_resp_rdata", l_rdata, exp_rdata);
      chk("l_resp_c_rvalid", {31'b0, c_rvalid}, 32'd0);
      step();
   endtask

   initial begin
      for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
      reset = 1'b0;
      c_req = 1'b1; c_we = 1'b0; c_funct3 = 3'b010; c_addr = 32'h40; c_wdata = '0;
      l_req = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0;
      step(); step();
      chk("rst_c_gnt", {31'b0, c_gnt}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_m_en", {31'b0, m_en}, 32'd0);
      chk("rst_c_rvalid", {31'b0, c_rvalid}, 32'd0);
      chk("rst_c_rdata", c_rdata, 32'd0);
      chk("rst_l_rdata", l_rdata, 32'd0);
      c_req = 1'b0;
      reset = 1'b1;
      step();

      tbl.push_back(mk(1, 3'b010, 32'h40, 32'h12345000, 4'hF, 32'h12345000, 32'h0, 0));
      tbl.push_back(mk(0, 3'b010, 32'h40, 32'h0,        4'h0, 32'h0,        32'h12345000, 0));
      tbl.push_back(mk(1, 3'b010, 32'h44, 32'h11223344, 4'hF, 32'h11223344, 32'h0, 0));
      tbl.push_back(mk(1, 3'b001, 32'h46, 32'hFFFFFA88, 4'hC, 32'hFA88FA88, 32'h0, 0));
      tbl.push_back(mk(0, 3'b001, 32'h46, 32'h0,        4'h0, 32'h0,        32'hFFFFFA88, 0));
      tbl.push_back(mk(0, 3'b101, 32'h46, 32'h0,        4'h0, 32'h0,        32'h0000FA88, 0));
      tbl.push_back(mk(1, 3'b000, 32'h47, 32'h00000088, 4'h8, 32'h88888888, 32'h0, 0));
      tbl.push_back(mk(0, 3'b000, 32'h47, 32'h0,        4'h0, 32'h0,        32'hFFFFFF88, 0));
      tbl.push_back(mk(0, 3'b100, 32'h47, 32'h0,        4'h0, 32'h0,        32'h00000088, 0));
      tbl.push_back(mk(0, 3'b010, 32'h44, 32'h0,        4'h0, 32'h0,        32'h88883344, 0));
      tbl.push_back(mk(1, 3'b000, 32'h41, 32'h0000005A, 4'h2, 32'h5A5A5A5A, 32'h0, 0));
      tbl.push_back(mk(0, 3'b000, 32'h41, 32'h0,        4'h0, 32'h0,        32'h0000005A, 0));
      tbl.push_back(mk(0, 3'b001, 32'h42, 32'h0,        4'h0, 32'h0,        32'h00001234, 0));
      tbl.push_back(mk(1, 3'b001, 32'h44, 32'h0000BEEF, 4'h3, 32'hBEEFBEEF, 32'h0, 0));
      tbl.push_back(mk(0, 3'b101, 32'h44, 32'h0,        4'h0, 32'h0,        32'h0000BEEF, 0));
      tbl.push_back(mk(0, 3'b000, 32'h44, 32'h0,        4'h0, 32'h0,        32'hFFFFFFEF, 0));
      tbl.push_back(mk(0, 3'b010, 32'h42, 32'h0,        4'h0, 32'h0,        32'h0, 1));
      tbl.push_back(mk(0, 3'b001, 32'h41, 32'h0,        4'h0, 32'h0,        32'h0, 1));
      tbl.push_back(mk(0, 3'b011, 32'h40, 32'h0,        4'h0, 32'h0,        32'h0, 1));
      tbl.push_back(mk(0, 3'b010, 32'h400, 32'h0,       4'h0, 32'h0,        32'h0, 1));
      tbl.push_back(mk(1, 3'b010, 32'h400, 32'hFFFFFFFF, 4'h0, 32'h0,       32'h0, 1));
      tbl.push_back(mk(1, 3'b001, 32'h43, 32'hFFFFFFFF, 4'h0, 32'h0,        32'h0, 1));
      tbl.push_back(mk(1, 3'b100, 32'h40, 32'hFFFFFFFF, 4'h0, 32'h0,        32'h0, 1));
      tbl.push_back(mk(0, 3'b010, 32'h40, 32'h0,        4'h0, 32'h0,        32'h12345A00, 0));
      tbl.push_back(mk(0, 3'b010, 32'h44, 32'h0,        4'h0, 32'h0,        32'h8888BEEF, 0));
      tbl.push_back(mk(0, 3'b010, 32'h00, 32'h0,        4'h0, 32'h0,        32'h0, 0));

      foreach (tbl[i]) core_op(tbl[i]);

      loader_op(1'b1, 8'h30, 32'hA5A50F0F, 32'h0);
      loader_op(1'b0, 8'h30, 32'h0, 32'hA5A50F0F);
      core_op(mk(0, 3'b100, 32'hC1, 32'h0, 4'h0, 32'h0, 32'h0000000F, 0));
      loader_op(1'b0, 8'h10, 32'h0, 32'h12345A00);

      // Contention: both requesters held from reset; grants alternate every 3 cycles.
      reset = 1'b0;
      c_req = 1'b1; c_we = 1'b0; c_funct3 = 3'b010; c_addr = 32'h40;
      l_req = 1'b1; l_we = 1'b0; l_addr = 8'h10;
      step();
      reset = 1'b1;
      #1;
      for (int cyc = 0; cyc < 12; cyc++) begin
         chk($sformatf("cont_c_gnt_%0d", cyc), {31'b0, c_gnt}, {31'b0, (cyc % 6) == 0});
         chk($sformatf("cont_l_gnt_%0d", cyc), {31'b0, l_gnt}, {31'b0, (cyc % 6) == 3});
         if ((cyc % 6) == 2) chk("cont_c_rdata", c_rdata, 32'h12345A00);
         if ((cyc % 6) == 5) begin
            chk("cont_l_rvalid", {31'b0, l_rvalid}, 32'd1);
            chk("cont_l_rdata", l_rdata, 32'h12345A00);
            chk("cont_c_rdata_idle", c_rdata, 32'h0);
         end
         step();
      end
      c_req = 1'b0; l_req = 1'b0;
      step(); step(); step();

      // Reset lands in ISSUE of a loader write.
      l_req = 1'b1; l_we = 1'b1; l_addr = 8'h20; l_wdata = 32'hDEADBEEF;
      begin
         logic seen;
         seen = 1'b0;
         for (int n = 0; n < 10; n++) begin
            if (l_gnt) begin seen = 1'b1; break; end
            step();
         end
         chk("mid_l_gnt", {31'b0, seen}, 32'd1);
      end
      step();
      l_req = 1'b0;
      chk("mid_m_en_before", {31'b0, m_en}, 32'd1);
      #1 reset = 1'b0;
      #1;
      chk("mid_m_en", {31'b0, m_en}, 32'd0);
      chk("mid_m_we", {28'b0, m_we}, 32'd0);
      chk("mid_m_addr", {24'b0, m_addr}, 32'd0);
      chk("mid_m_wdata", m_wdata, 32'd0);
      chk("mid_busy", {31'b0, busy}, 32'd0);
      step();
      chk("mid_no_rvalid1", {31'b0, l_rvalid}, 32'd0);
      step();
      chk("mid_no_rvalid2", {31'b0, l_rvalid}, 32'd0);
      reset = 1'b1;
      c_req = 1'b1; c_we = 1'b0; c_funct3 = 3'b010; c_addr = 32'h40;
      #1;
      chk("post_rst_c_gnt", {31'b0, c_gnt}, 32'd1);
      step();
      c_req = 1'b0;
      chk("post_rst_l_rvalid", {31'b0, l_rvalid}, 32'd0);
      step();
      chk("post_rst_c_rvalid", {31'b0, c_rvalid}, 32'd1);
      chk("post_rst_c_rdata", c_rdata, 32'h12345A00);
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1);
   end

endmodule
